// File: rtl/accumulator_pkg.sv
// Shared definitions for the accumulator unit: FSM state encoding and
// default sizing constants.
package accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int WIDTH_DEF = 4;
  localparam int N_OPS_DEF = 4;

endpackage

// File: rtl/adder_core.sv
// WIDTH-bit ripple-carry adder built from a chain of full adders.
// Carry-in is tied low; the final carry is exported as cout.
module adder_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/accumulator_unit.sv
// Accumulator unit: sums N_OPS unsigned operands through a valid/ready
// input, then holds the result in DONE until the consumer acknowledges.
// Optional build macro ACC_SATURATE_EN: a carrying addition clamps the
// accumulator to all-ones instead of wrapping.
module accumulator_unit
  import accumulator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_OPS = N_OPS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc_out,
  output logic             carry_out,
  output logic             overflow,
  output logic [3:0]       count
);

`ifdef ACC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Count value held just before the final operand of a result arrives.
  localparam logic [3:0] LAST_CNT = 4'(N_OPS - 1);

  // Clamp to all-ones on carry when saturation is built in, else wrap.
  function automatic logic [WIDTH-1:0] sat_or_wrap(input logic [WIDTH-1:0] s,
                                                   input logic             c);
    return (SAT_EN && c) ? {WIDTH{1'b1}} : s;
  endfunction

  state_t           state_p1;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc_p1;
  logic             carry_p1;
  logic             ovf_p1;
  logic [3:0]       cnt_p1;

  logic [WIDTH-1:0] sum_p0;
  logic             cout_p0;
  logic             accept_p0;
  logic             last_p0;
  logic             ack_p0;

  // Stage p0: combinational handshake decode and addition
  assign in_ready  = (state_p1 != DONE);
  assign out_valid = (state_p1 == DONE);
  assign accept_p0 = in_valid && in_ready;
  assign last_p0   = (cnt_p1 == LAST_CNT);
  assign ack_p0    = (state_p1 == DONE) && out_ready;

  adder_core #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a   (acc_p1),
    .b   (in_data),
    .sum (sum_p0),
    .cout(cout_p0)
  );

  // Next-state logic; clear overrides every other transition.
  always_comb begin
    state_nxt = state_p1;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state_p1)
        IDLE: begin
          if (accept_p0) state_nxt = last_p0 ? DONE : ACCUM;
        end
        ACCUM: begin
          if (accept_p0 && last_p0) state_nxt = DONE;
        end
        DONE: begin
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p1: FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_p1 <= IDLE;
    else     state_p1 <= state_nxt;
  end

  // Stage p1: accumulator, flags and operand count; zeroed on reset,
  // clear or result acknowledge, updated only on an accepted operand.
  always_ff @(posedge clk) begin
    if (rst || clear || ack_p0) begin
      acc_p1   <= '0;
      carry_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
      cnt_p1   <= '0;
    end else if (accept_p0) begin
      acc_p1   <= sat_or_wrap(sum_p0, cout_p0);
      carry_p1 <= cout_p0;
      ovf_p1   <= ovf_p1 | cout_p0;
      cnt_p1   <= cnt_p1 + 4'd1;
    end
  end

  assign acc_out   = acc_p1;
  assign carry_out = carry_p1;
  assign overflow  = ovf_p1;
  assign count     = cnt_p1;

endmodule
